// File: rtl/tlu_trigger_checker.sv
// Trigger sequence checker in a FWFT stream: forwards every word unchanged, counts
// trigger-number gaps and duplicates, and can insert a marker word ahead of a bad trigger.
module tlu_trigger_checker #(
  parameter int          TRIGGER_BITS = 15,
  parameter logic [2:0]  MARKER_ID    = 3'b111
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_EMPTY,
  input  logic [31:0]             IN_DATA,
  output logic                    IN_READ,
  output logic                    OUT_EMPTY,
  output logic [31:0]             OUT_DATA,
  input  logic                    OUT_READ,
  input  logic                    ENABLE_MARKER,
  input  logic                    CLEAR,
  output logic [15:0]             ERR_CNT,
  output logic [15:0]             DUP_CNT,
  output logic [31:0]             MISSING_CNT,
  output logic [TRIGGER_BITS-1:0] LAST_TRIGGER
);

  logic [31:0]             buf_q [3];
  logic [31:0]             buf_d [3];
  logic [1:0]              count_q, count_d;
  logic                    first_q, first_d;
  logic [15:0]             err_q, err_d;
  logic [15:0]             dup_q, dup_d;
  logic [31:0]             miss_q, miss_d;
  logic [TRIGGER_BITS-1:0] last_q, last_d;

  logic                    in_read;
  logic                    pop;
  logic                    is_trig;
  logic                    is_dup;
  logic                    is_good;
  logic                    marker_ins;
  logic [TRIGGER_BITS-1:0] num;
  logic [TRIGGER_BITS-1:0] delta;
  logic [15:0]             delta16;
  logic [32:0]             miss_sum;
  logic [31:0]             marker_word;
  logic [31:0]             w0;
  logic [1:0]              base;

  always_comb begin
    in_read  = !IN_EMPTY && (count_q <= 2'd1);
    pop      = OUT_READ && (count_q != 2'd0);
    num      = IN_DATA[TRIGGER_BITS-1:0];
    is_trig  = in_read && IN_DATA[31];
    is_dup   = (num == last_q);
    is_good  = (num == last_q + TRIGGER_BITS'(1));
    delta    = num - last_q - TRIGGER_BITS'(1);
    // a duplicate reports zero missing numbers, not the wrapped difference
    delta16  = is_dup ? 16'h0000 : 16'(delta);
    miss_sum = {1'b0, miss_q} + 33'(delta16);
    marker_word = {1'b0, MARKER_ID, 12'h000, delta16};

    err_d      = err_q;
    dup_d      = dup_q;
    miss_d     = miss_q;
    last_d     = last_q;
    first_d    = first_q;
    marker_ins = 1'b0;

    if (CLEAR) begin
      err_d   = 16'h0000;
      dup_d   = 16'h0000;
      miss_d  = 32'h0000_0000;
      first_d = 1'b1;
      if (is_trig) begin
        last_d  = num;
        first_d = 1'b0;
      end
    end else if (is_trig) begin
      last_d  = num;
      first_d = 1'b0;
      if (!first_q && !is_good) begin
        marker_ins = ENABLE_MARKER;
        if (is_dup) begin
          if (dup_q != 16'hFFFF) dup_d = dup_q + 16'd1;
        end else begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          miss_d = miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];
        end
      end
    end

    // shift-down buffer: head always sits in entry 0
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    buf_d[2] = buf_q[2];
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
    end
    base = count_q - {1'b0, pop};
    w0   = marker_ins ? marker_word : IN_DATA;
    for (int i = 0; i < 3; i++) begin
      if (in_read && (2'(i) == base)) buf_d[i] = w0;
      if (in_read && marker_ins && (2'(i) == base + 2'd1)) buf_d[i] = IN_DATA;
    end
    count_d = count_q - {1'b0, pop} + {1'b0, in_read} + {1'b0, marker_ins};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_q[0] <= 32'h0;
      buf_q[1] <= 32'h0;
      buf_q[2] <= 32'h0;
      count_q  <= 2'd0;
      first_q  <= 1'b1;
      err_q    <= 16'h0;
      dup_q    <= 16'h0;
      miss_q   <= 32'h0;
      last_q   <= '0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      buf_q[2] <= buf_d[2];
      count_q  <= count_d;
      first_q  <= first_d;
      err_q    <= err_d;
      dup_q    <= dup_d;
      miss_q   <= miss_d;
      last_q   <= last_d;
    end
  end

  assign IN_READ      = in_read;
  assign OUT_EMPTY    = (count_q == 2'd0);
  assign OUT_DATA     = buf_q[0];
  assign ERR_CNT      = err_q;
  assign DUP_CNT      = dup_q;
  assign MISSING_CNT  = miss_q;
  assign LAST_TRIGGER = last_q;

endmodule

// File: tb/tb_tlu_trigger_checker.sv
// Bench for tlu_trigger_checker: directed scenarios plus random traffic, all scored
// against a queue-based reference of the expected output stream and counters.
module tb_tlu_trigger_checker;
  localparam int TB = 15;
  localparam int M  = 1 << TB;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_EMPTY = 1'b1;
  logic [31:0] IN_DATA = 32'h0;
  logic        IN_READ;
  logic        OUT_EMPTY;
  logic [31:0] OUT_DATA;
  logic        OUT_READ = 1'b0;
  logic        ENABLE_MARKER = 1'b0;
  logic        CLEAR = 1'b0;
  logic [15:0] ERR_CNT;
  logic [15:0] DUP_CNT;
  logic [31:0] MISSING_CNT;
  logic [TB-1:0] LAST_TRIGGER;

  tlu_trigger_checker #(.TRIGGER_BITS(TB), .MARKER_ID(3'b111)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_EMPTY(IN_EMPTY), .IN_DATA(IN_DATA),
    .IN_READ(IN_READ), .OUT_EMPTY(OUT_EMPTY), .OUT_DATA(OUT_DATA),
    .OUT_READ(OUT_READ), .ENABLE_MARKER(ENABLE_MARKER), .CLEAR(CLEAR),
    .ERR_CNT(ERR_CNT), .DUP_CNT(DUP_CNT), .MISSING_CNT(MISSING_CNT),
    .LAST_TRIGGER(LAST_TRIGGER)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] src[$];
  logic [31:0] exp_q[$];
  int          m_err, m_dup, m_last;
  longint      m_miss;
  bit          m_first;

  task automatic model_reset();
    exp_q.delete();
    m_err = 0; m_dup = 0; m_miss = 0; m_last = 0; m_first = 1;
  endtask

  // Reference behaviour for one popped word (or a bare CLEAR when accept=0).
  task automatic model_tick(input bit accept, input logic [31:0] w, input bit en, input bit clr);
    int num, diff;
    num = int'(w[TB-1:0]);
    if (clr) begin
      m_err = 0; m_dup = 0; m_miss = 0; m_first = 1;
      if (accept && w[31]) begin m_last = num; m_first = 0; end
      if (accept) exp_q.push_back(w);
      return;
    end
    if (!accept) return;
    if (w[31]) begin
      if (m_first) begin
        m_first = 0;
      end else begin
        diff = (num - m_last + M) % M;
        if (diff == 0) begin
          if (m_dup < 65535) m_dup++;
          if (en) exp_q.push_back(32'h7000_0000);
        end else if (diff != 1) begin
          if (m_err < 65535) m_err++;
          m_miss = m_miss + (diff - 1);
          if (m_miss > 64'hFFFF_FFFF) m_miss = 64'hFFFF_FFFF;
          if (en) exp_q.push_back(32'h7000_0000 + 32'(diff - 1));
        end
      end
      m_last = num;
    end
    exp_q.push_back(w);
  endtask

  // One clock: drive inputs after negedge, score the stream, advance the model.
  task automatic drive_cycle(input bit rd, input bit en, input bit clr);
    bit exp_rd, acc, pop;
    logic [31:0] w;
    OUT_READ = rd; ENABLE_MARKER = en; CLEAR = clr;
    IN_EMPTY = (src.size() == 0);
    IN_DATA  = (src.size() == 0) ? 32'h0 : src[0];
    #1;
    exp_rd = (src.size() != 0) && (exp_q.size() <= 1);
    checks++;
    if (IN_READ !== exp_rd) begin
      errors++; $display("FAIL in_read: got %b expected %b", IN_READ, exp_rd);
    end
    checks++;
    if (OUT_EMPTY !== (exp_q.size() == 0)) begin
      errors++; $display("FAIL out_empty: got %b expected %b", OUT_EMPTY, exp_q.size() == 0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (OUT_DATA !== exp_q[0]) begin
        errors++; $display("FAIL out_data: got %h expected %h", OUT_DATA, exp_q[0]);
      end
    end
    pop = rd && (exp_q.size() != 0);
    acc = exp_rd;
    w   = acc ? src[0] : 32'h0;
    @(posedge CLK);
    if (pop) void'(exp_q.pop_front());
    if (acc) void'(src.pop_front());
    model_tick(acc, w, en, clr);
    @(negedge CLK);
  endtask

  task automatic drain(input bit en);
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < 100) begin
      drive_cycle(1'b1, en, 1'b0);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL drain_timeout: got %0d words left expected 0", src.size() + exp_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (ERR_CNT !== 16'(m_err) || DUP_CNT !== 16'(m_dup) || MISSING_CNT !== 32'(m_miss)
        || LAST_TRIGGER !== TB'(m_last)) begin
      errors++;
      $display("FAIL %s counters: got err=%0d dup=%0d miss=%0d last=%0d expected err=%0d dup=%0d miss=%0d last=%0d",
               tag, ERR_CNT, DUP_CNT, MISSING_CNT, LAST_TRIGGER, m_err, m_dup, m_miss, m_last);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    model_reset();
    #3;
    checks++;
    if (OUT_EMPTY !== 1'b1 || OUT_DATA !== 32'h0 || IN_READ !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got empty=%b data=%h in_read=%b expected 1 0 0", OUT_EMPTY, OUT_DATA, IN_READ);
    end
    checks++;
    if (ERR_CNT !== 16'h0 || DUP_CNT !== 16'h0 || MISSING_CNT !== 32'h0 || LAST_TRIGGER !== '0) begin
      errors++; $display("FAIL reset_counters: got %h %h %h %h expected all 0", ERR_CNT, DUP_CNT, MISSING_CNT, LAST_TRIGGER);
    end
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    src = '{32'h8000_0005, 32'h8000_0006, 32'h0000_1234, 32'h8000_0007};
    drain(1'b1);
    check_counters("basic");
    checks++;
    if (ERR_CNT !== 16'h0 || LAST_TRIGGER !== TB'(7)) begin
      errors++; $display("FAIL basic_const: got err=%0d last=%0d expected 0 7", ERR_CNT, LAST_TRIGGER);
    end
  endtask

  task automatic test_gap_marker();
    drive_cycle(1'b1, 1'b1, 1'b1);
    src = '{32'h8000_000A, 32'h8000_000E};
    drain(1'b1);
    check_counters("gap");
    checks++;
    if (ERR_CNT !== 16'd1 || MISSING_CNT !== 32'd3) begin
      errors++; $display("FAIL gap_const: got err=%0d miss=%0d expected 1 3", ERR_CNT, MISSING_CNT);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 1'b1, 1'b1);
    src = '{32'h8000_7FFF, 32'h8000_0000, 32'h8000_0000};
    drain(1'b1);
    check_counters("wrap");
    checks++;
    if (ERR_CNT !== 16'd0 || DUP_CNT !== 16'd1) begin
      errors++; $display("FAIL wrap_const: got err=%0d dup=%0d expected 0 1", ERR_CNT, DUP_CNT);
    end
  endtask

  task automatic test_stall();
    src = '{32'h8000_0001, 32'h0000_00AA, 32'h8000_0005, 32'h0000_00BB, 32'h8000_0006};
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (IN_READ !== 1'b0 || OUT_DATA !== 32'h8000_0001) begin
      errors++; $display("FAIL stall_hold: got in_read=%b head=%h expected 0 80000001", IN_READ, OUT_DATA);
    end
    drain(1'b1);
    check_counters("stall");
  endtask

  task automatic test_clear_collision();
    src = '{32'h8000_0014};
    drain(1'b0);
    src = '{32'h8000_0032};
    drive_cycle(1'b1, 1'b1, 1'b1);
    src = '{32'h8000_0033};
    drain(1'b1);
    check_counters("clear");
    checks++;
    if (LAST_TRIGGER !== TB'(51) || ERR_CNT !== 16'd0 || MISSING_CNT !== 32'd0) begin
      errors++; $display("FAIL clear_const: got last=%0d err=%0d expected 51 0", LAST_TRIGGER, ERR_CNT);
    end
  endtask

  task automatic test_mid_reset();
    src = '{32'h8000_0100, 32'h8000_0200, 32'h8000_0300};
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    RST_N = 1'b0;
    src.delete();
    IN_EMPTY = 1'b1;
    #1;
    model_reset();
    checks++;
    if (OUT_EMPTY !== 1'b1 || ERR_CNT !== 16'h0 || MISSING_CNT !== 32'h0) begin
      errors++; $display("FAIL midreset: got empty=%b err=%0d miss=%0d expected 1 0 0", OUT_EMPTY, ERR_CNT, MISSING_CNT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    src = '{32'h8000_0456, 32'h8000_0457};
    drain(1'b1);
    check_counters("midreset");
  endtask

  task automatic test_random();
    int gen = 0;
    int r;
    bit en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (src.size() < 2 && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 11);
        if (r < 3) src.push_back({1'b0, 31'($urandom)});
        else begin
          if (r == 3) gen = gen;
          else if (r == 4) gen = $urandom_range(0, M - 1);
          else if (r == 5) gen = (gen + $urandom_range(2, 40)) % M;
          else gen = (gen + 1) % M;
          src.push_back({1'b1, 16'($urandom), TB'(gen)});
        end
      end
      if (c % 97 == 0) en = $urandom_range(0, 1);
      drive_cycle($urandom_range(0, 9) < 7, en, $urandom_range(0, 99) < 2);
      if (c % 250 == 249) check_counters("random");
    end
    drain(en);
    check_counters("random_end");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_gap_marker();
    test_wrap();
    test_stall();
    test_clear_collision();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
